// File: rtl/game_progress_tracker_if.sv
// game_progress_tracker_if
// Bundles the tracker's phase qualifiers and hit pulses (driven by the
// controller and collision logic) with the progress outputs it returns.
// NUM_ENEMIES must match the parameter of the attached tracker.
interface game_progress_tracker_if #(
  parameter int NUM_ENEMIES = 16
);
  localparam int IDX_W = $clog2(NUM_ENEMIES);

  // Phase qualifiers and hit pulses into the tracker
  logic             start;
  logic             play;
  logic             boss_fight;
  logic             frame_tick;
  logic             enemy_hit_valid;
  logic [IDX_W-1:0] enemy_hit_idx;
  logic             boss_hit;
  logic             ship_hit;

  // Progress outputs from the tracker
  logic                   died;
  logic                   killed_all1;
  logic                   killed_all2;
  logic [NUM_ENEMIES-1:0] enemy_alive;
  logic [5:0]             enemies_left;
  logic [7:0]             boss_hp;
  logic [2:0]             lives;
  logic                   invuln;
  logic [15:0]            score;

  modport master (
    output start, play, boss_fight, frame_tick,
    output enemy_hit_valid, enemy_hit_idx, boss_hit, ship_hit,
    input  died, killed_all1, killed_all2, enemy_alive, enemies_left,
    input  boss_hp, lives, invuln, score
  );

  modport slave (
    input  start, play, boss_fight, frame_tick,
    input  enemy_hit_valid, enemy_hit_idx, boss_hit, ship_hit,
    output died, killed_all1, killed_all2, enemy_alive, enemies_left,
    output boss_hp, lives, invuln, score
  );
endinterface

// File: rtl/game_progress_tracker.sv
// game_progress_tracker
// Tracks wave-1 enemy survival, boss hit points, ship lives and post-hit
// invulnerability, and raises the died / killed_all1 / killed_all2 flags
// for the downstream game controller.
// Optional feature macro: GAME_PROGRESS_SCORE_EN enables the score register
// (10 per enemy, 50 per boss hit, saturating); without it score reads 0.
module game_progress_tracker #(
  parameter int NUM_ENEMIES   = 16,
  parameter int BOSS_HP       = 8,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic                    Clk,
  input logic                    Reset,
  game_progress_tracker_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ENEMIES);

  localparam logic [5:0] ENEMIES_INIT = 6'(NUM_ENEMIES);
  localparam logic [7:0] BOSS_HP_INIT = 8'(BOSS_HP);
  localparam logic [2:0] LIVES_INIT   = 3'(LIVES);
  localparam logic [7:0] INVULN_INIT  = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAVE1 = 2'd1,
    BOSS  = 2'd2,
    OVER  = 2'd3
  } phase_t;

  phase_t                 phase_reg,   phase_next;
  logic [NUM_ENEMIES-1:0] alive_reg,   alive_next;
  logic [5:0]             left_reg,    left_next;
  logic [7:0]             boss_hp_reg, boss_hp_next;
  logic [2:0]             lives_reg,   lives_next;
  logic [7:0]             inv_cnt_reg, inv_cnt_next;
  logic                   died_reg,    died_next;
  logic                   ka1_reg,     ka1_next;
  logic                   ka2_reg,     ka2_next;

  logic [NUM_ENEMIES-1:0] hit_vec;
  logic                   enemy_acc;
  logic                   boss_acc;
  logic                   ship_acc;

  // One-hot decode of the struck enemy; indices >= NUM_ENEMIES match nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENEMIES; gi++) begin : g_hit_dec
      assign hit_vec[gi] = bus.enemy_hit_valid &&
                           (bus.enemy_hit_idx == IDX_W'(gi));
    end
  endgenerate

  // Hit acceptance: each hit type is qualified by phase, controller state and
  // the current target state.
  always_comb begin
    enemy_acc = (phase_reg == WAVE1) && bus.play && |(hit_vec & alive_reg);
    boss_acc  = (phase_reg == BOSS) && bus.boss_fight && bus.boss_hit &&
                (boss_hp_reg != 8'd0);
    ship_acc  = ((phase_reg == WAVE1) || (phase_reg == BOSS)) &&
                (bus.play || bus.boss_fight) && bus.ship_hit &&
                (inv_cnt_reg == 8'd0) && (lives_reg != 3'd0);
  end

  // Next-state and phase logic; start overrides everything with a full reinit.
  always_comb begin
    phase_next   = phase_reg;
    alive_next   = alive_reg;
    boss_hp_next = boss_hp_reg;
    lives_next   = lives_reg;
    inv_cnt_next = inv_cnt_reg;
    died_next    = died_reg;
    ka1_next     = ka1_reg;
    ka2_next     = ka2_reg;

    if (bus.start) begin
      phase_next   = IDLE;
      alive_next   = '1;
      boss_hp_next = BOSS_HP_INIT;
      lives_next   = LIVES_INIT;
      inv_cnt_next = 8'd0;
      died_next    = 1'b0;
      ka1_next     = 1'b0;
      ka2_next     = 1'b0;
    end else begin
      if (enemy_acc) begin
        alive_next = alive_reg & ~hit_vec;
      end
      ka1_next = ka1_reg | (alive_next == '0);

      if (boss_acc) begin
        boss_hp_next = boss_hp_reg - 8'd1;
        if (boss_hp_reg == 8'd1) begin
          ka2_next = 1'b1;
        end
      end

      // A freshly loaded invulnerability window ignores a same-cycle tick.
      if (ship_acc) begin
        lives_next = lives_reg - 3'd1;
        if (lives_reg == 3'd1) begin
          died_next = 1'b1;
        end else begin
          inv_cnt_next = INVULN_INIT;
        end
      end else if (bus.frame_tick && (inv_cnt_reg != 8'd0)) begin
        inv_cnt_next = inv_cnt_reg - 8'd1;
      end

      // Entering BOSS is checked before a death on the same edge.
      case (phase_reg)
        IDLE: begin
          if (bus.play) phase_next = WAVE1;
        end
        WAVE1: begin
          if (bus.boss_fight)             phase_next = BOSS;
          else if (died_next && !died_reg) phase_next = OVER;
        end
        BOSS: begin
          if ((died_next && !died_reg) || (ka2_next && !ka2_reg))
            phase_next = OVER;
        end
        default: ;
      endcase
    end
  end

  // Population count of the next alive mask, registered alongside it.
  always_comb begin
    left_next = 6'd0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      left_next = left_next + {5'd0, alive_next[i]};
    end
  end

  // State registers with synchronous reset to the reinit values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase_reg   <= IDLE;
      alive_reg   <= '1;
      left_reg    <= ENEMIES_INIT;
      boss_hp_reg <= BOSS_HP_INIT;
      lives_reg   <= LIVES_INIT;
      inv_cnt_reg <= 8'd0;
      died_reg    <= 1'b0;
      ka1_reg     <= 1'b0;
      ka2_reg     <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      alive_reg   <= alive_next;
      left_reg    <= left_next;
      boss_hp_reg <= boss_hp_next;
      lives_reg   <= lives_next;
      inv_cnt_reg <= inv_cnt_next;
      died_reg    <= died_next;
      ka1_reg     <= ka1_next;
      ka2_reg     <= ka2_next;
    end
  end

`ifdef GAME_PROGRESS_SCORE_EN
  logic [15:0] score_reg, score_next;
  logic [16:0] score_sum;

  // Score credit: enemy and boss credits sum, then saturate at all ones.
  always_comb begin
    score_sum = {1'b0, score_reg} +
                (enemy_acc ? 17'd10 : 17'd0) +
                (boss_acc  ? 17'd50 : 17'd0);
    if (bus.start)         score_next = 16'd0;
    else if (score_sum[16]) score_next = 16'hFFFF;
    else                   score_next = score_sum[15:0];
  end

  // Score register.
  always_ff @(posedge Clk) begin
    if (Reset) score_reg <= 16'd0;
    else       score_reg <= score_next;
  end

  assign bus.score = score_reg;
`else
  assign bus.score = 16'd0;
`endif

  assign bus.died         = died_reg;
  assign bus.killed_all1  = ka1_reg;
  assign bus.killed_all2  = ka2_reg;
  assign bus.enemy_alive  = alive_reg;
  assign bus.enemies_left = left_reg;
  assign bus.boss_hp      = boss_hp_reg;
  assign bus.lives        = lives_reg;
  assign bus.invuln       = (inv_cnt_reg != 8'd0);

endmodule

// File: doc/game_progress_tracker.md
# game_progress_tracker

- Tracks wave-1 enemy survival, boss hit points, ship lives and post-hit invulnerability.
- Produces the registered `died`, `killed_all1` and `killed_all2` flags consumed by `signal_controller`.
- Sits directly upstream of `signal_controller`, between the collision-detection logic and the game FSM. It takes that FSM's `start`/`play`/`boss_fight` state outputs back as phase qualifiers.

## Interface
Parameters:
- NUM_ENEMIES, 16, number of wave-1 enemies (2..32)
- BOSS_HP, 8, boss hit points (1..255)
- LIVES, 3, ship lives per game (1..7)
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal ship hit (1..255)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- start  in  1  controller START state; level; reinitialises the tracker
- play  in  1  controller PLAY state
- boss_fight  in  1  controller BOSS_FIGHT state
- frame_tick  in  1  one-cycle pulse per video frame
- enemy_hit_valid  in  1  one-cycle pulse: enemy `enemy_hit_idx` was struck
- enemy_hit_idx  in  $clog2(NUM_ENEMIES)  index of the struck enemy
- boss_hit  in  1  one-cycle pulse: boss struck
- ship_hit  in  1  one-cycle pulse: player ship struck
- died  out  1  lives exhausted (level)
- killed_all1  out  1  all wave-1 enemies destroyed (level)
- killed_all2  out  1  boss destroyed (level)
- enemy_alive  out  NUM_ENEMIES  per-enemy alive mask
- enemies_left  out  6  population count of `enemy_alive`
- boss_hp  out  8  remaining boss hit points
- lives  out  3  remaining lives
- invuln  out  1  ship currently invulnerable
- score  out  16  game score

## Operation
- Phase FSM with states IDLE, WAVE1, BOSS, OVER; transitions evaluated in this order:
  - `start`=1 in any state → IDLE, with full reinit (same values as reset).
  - IDLE → WAVE1 when `play`.
  - WAVE1 → BOSS when `boss_fight`.
  - WAVE1 or BOSS → OVER on the edge that sets `died`.
  - BOSS → OVER on the edge that sets `killed_all2`.
  - OVER exits only via `start`.
- Enemy hit accepted only when phase=WAVE1, `play`=1, `enemy_hit_idx` < NUM_ENEMIES and that enemy's alive bit=1.
  - An accepted hit clears the alive bit.
  - Hits on dead enemies or out-of-range indices are ignored.
- `killed_all1` is set on the edge where `enemy_alive` becomes all-zero and holds until reinit.
- Boss hit accepted only when phase=BOSS, `boss_fight`=1 and `boss_hp`>0.
  - An accepted hit decrements `boss_hp` by 1.
  - `killed_all2` is set on the edge where `boss_hp` reaches 0.
- Ship hit accepted only when phase is WAVE1 or BOSS, (`play`|`boss_fight`)=1, `invuln`=0 and `lives`>0. An accepted hit decrements `lives` by 1:
  - If `lives` was 1, `died` is set.
  - Otherwise the invulnerability counter is loaded with INVULN_FRAMES.
- Invulnerability counter:
  - Decrements on each `frame_tick` while nonzero and saturates at 0.
  - `invuln` = (counter != 0), combinational from the register.
- Simultaneous events in one cycle are all processed independently on the same edge, including enemy hit plus ship hit.
  - `died` and `killed_all1` may rise together; `signal_controller` prioritises `died`.
  - A `frame_tick` in the same cycle as an accepted ship hit does not decrement the freshly loaded counter.
- In OVER, and when no phase qualifier is high, all hit inputs are ignored.
- Reset/reinit values:
  - `died`=0, `killed_all1`=0, `killed_all2`=0
  - `enemy_alive`=all ones, `enemies_left`=NUM_ENEMIES
  - `boss_hp`=BOSS_HP, `lives`=LIVES, `invuln`=0, `score`=0
  - phase=IDLE

## Timing
- All state registered; every output changes only on `Clk` rising edge.
- Latency from a hit pulse to the updated count or flag is 1 cycle.
- The controller observes the flag on the following edge, so 2 cycles from hit pulse to controller state change.
- Hit inputs are single-cycle pulses. A level held N cycles counts as N hits, subject to the acceptance rules, so `ship_hit` is effectively single-shot because of `invuln`.
- `enemies_left` is registered together with `enemy_alive` on the same edge.
- `Reset` and `start` take effect on the next edge regardless of other inputs, including mid-wave.

## Configuration
- `GAME_PROGRESS_SCORE_EN` defined:
  - `score` adds 10 per accepted enemy hit and 50 per accepted boss hit.
  - Simultaneous credits sum in one cycle.
  - `score` saturates at 16'hFFFF and clears on reinit.
- `GAME_PROGRESS_SCORE_EN` undefined: no score register; `score` is tied to 0.

## Test plan
- Reset, then `start`=1 for one cycle, then `play`=1 → `enemy_alive`=16'hFFFF, `lives`=3, `boss_hp`=8, all flags 0, phase WAVE1.
- Hit indices 0..15 once each, one pulse per cycle, index 5 hit twice → `killed_all1` rises 1 cycle after the index-15 pulse. With the score macro enabled, `score`=160.
- Three `ship_hit` pulses spaced by ≥61 `frame_tick`s → `lives` 2, 1, 0; `died` rises 1 cycle after the third pulse.
- A second `ship_hit` 5 frames after the first → ignored, `lives` stays 2, `invuln`=1 until 60 ticks have elapsed.
- `boss_fight`=1, 8 `boss_hit` pulses, then a 9th → `killed_all2` after the 8th, `boss_hp`=0, 9th ignored. With the score macro enabled, `score`=560.
- Same-cycle final enemy hit and fatal ship hit → `died` and `killed_all1` both rise on the same edge. Then `start`=1 mid-OVER → all outputs return to reset values.
